lsu: RTL



---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
// Holds funct3 size codes, FSM states, byte-enable type and misalign check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    typedef logic [3:0] be_t;

    // Bytes are never misaligned; halves need addr[0]=0; everything
    // else (W and the unused codes) is treated as a word.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            default:     return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
// Ports: i_st_f3/i_st_off/i_st_data -> o_be/o_wdata (store side);
//        i_ld_f3/i_ld_off/i_rdata  -> o_ld_data (load side).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_f3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output be_t         o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_f3)
            F3_B, F3_BU: begin
                o_be    = be_t'(4'b0001 << i_st_off);
                o_wdata = {4{i_st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                o_be    = be_t'(4'b0011 << {i_st_off[1], 1'b0});
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_st_data;
            end
        endcase
    end

    always_comb begin
        w_byte    = i_rdata[{i_ld_off, 3'b000} +: 8];
        w_half    = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
        o_ld_data = i_rdata;
        case (i_ld_f3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'd0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: M-stage load/store unit on a req/gnt/rvalid bus; stalls the pipe
// until done. Optional macro LSU_MISALIGN_EXC_EN traps misaligned H/W.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallMemM,
    output logic        MisalignM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    state_t      w_next;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    be_t         r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic        r_mis;

    logic        w_access;
    logic        w_mis;
    logic        w_issue;
    logic        w_stall;
    be_t         w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld;

    assign w_access = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_EXC_EN
    assign w_mis = w_access & is_misaligned(funct3M, ALUResultM[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    lsu_align u_align (
        .i_st_f3   (funct3M),
        .i_st_off  (ALUResultM[1:0]),
        .i_st_data (WriteDataM),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_ld_f3   (r_f3),
        .i_ld_off  (r_off),
        .i_rdata   (mem_rdata),
        .o_ld_data (w_ld)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && !w_mis) begin
                    w_next  = REQ;
                    w_issue = 1'b1;
                end
            end
            REQ:     if (mem_gnt) w_next = r_we ? DONE : WAIT;
            WAIT:    if (mem_rvalid) w_next = DONE;
            default: w_next = IDLE;
        endcase
        // A trapped access in IDLE must not hold the pipeline.
        w_stall = w_access && (r_state != DONE)
                  && !((r_state == IDLE) && w_mis);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_off   <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_mis <= (r_state == IDLE) && w_mis;
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= MemWriteM;
                r_addr  <= {ALUResultM[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_f3    <= funct3M;
                r_off   <= ALUResultM[1:0];
            end else if ((r_state == REQ) && mem_gnt) begin
                r_req <= 1'b0;
            end
            if ((r_state == WAIT) && mem_rvalid) r_rdata <= w_ld;
        end
    end

    assign ReadDataM = r_rdata;
    assign StallMemM = w_stall;
    assign MisalignM = r_mis;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

endmodule
